wb_line_master: RTL and testbench



---
 rtl/wb_line_pkg.sv | 26 ++
 rtl/wb_line_master_if.sv | 54 +++++
 rtl/wb_line_master.sv | 204 ++++++++++++++++++++
 tb/tb_wb_line_master.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_line_pkg.sv
// Shared types and width helpers for the Wishbone line master.
package wb_line_pkg;

  localparam int DEF_ADDR_WIDTH     = 25;
  localparam int DEF_DATA_WIDTH     = 64;
  localparam int DEF_LINE_WIDTH     = 512;
  localparam int DEF_TIMEOUT_CYCLES = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    RESP = 2'd2
  } line_state_e;

  function automatic int line_beats(input int line_width, input int data_width);
    return line_width / data_width;
  endfunction

  // Single-beat lines still get a one-bit index so vectors stay non-empty.
  function automatic int beat_idx_width(input int line_width, input int data_width);
    int beats;
    beats = line_width / data_width;
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/wb_line_master_if.sv
// Line request/response channel and Wishbone bus bundles used by wb_line_master.
interface wb_line_req_if
  import wb_line_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_WIDTH = DEF_LINE_WIDTH
);
  logic                    req_valid_i;
  logic                    req_ready_o;
  logic                    req_we_i;
  logic [ADDR_WIDTH-1:0]   req_addr_i;
  logic [LINE_WIDTH-1:0]   req_wdata_i;
  logic [LINE_WIDTH/8-1:0] req_wmask_i;
  logic                    resp_valid_o;
  logic                    resp_ready_i;
  logic [LINE_WIDTH-1:0]   resp_rdata_o;
  logic                    resp_err_o;

  modport master (
    output req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i, resp_ready_i,
    input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );

  modport slave (
    input  req_valid_i, req_we_i, req_addr_i, req_wdata_i, req_wmask_i, resp_ready_i,
    output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o
  );
endinterface

interface wb_bus_if
  import wb_line_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [ADDR_WIDTH-1:0]   adr_o;
  logic [DATA_WIDTH-1:0]   dat_o;
  logic [DATA_WIDTH/8-1:0] sel_o;
  logic                    we_o;
  logic                    cyc_o;
  logic                    stb_o;
  logic                    ack_i;
  logic [DATA_WIDTH-1:0]   dat_i;

  modport master (
    output adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
    input  ack_i, dat_i
  );

  modport slave (
    input  adr_o, dat_o, sel_o, we_o, cyc_o, stb_o,
    output ack_i, dat_i
  );
endinterface

// File: rtl/wb_line_master.sv
// Splits one cache-line read/write into single-beat Wishbone accesses, skipping zero-mask write beats.
// Optional ack watchdog enabled by defining WB_LINE_MASTER_TIMEOUT_EN.
module wb_line_master
  import wb_line_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int LINE_WIDTH     = DEF_LINE_WIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  wb_line_req_if.slave req,
  wb_bus_if.master     wb
);

  localparam int BEATS  = line_beats(LINE_WIDTH, DATA_WIDTH);
  localparam int IDX_W  = beat_idx_width(LINE_WIDTH, DATA_WIDTH);
  localparam int SEL_W  = DATA_WIDTH / 8;
  localparam int MASK_W = LINE_WIDTH / 8;

  if (DATA_WIDTH < 8 || (DATA_WIDTH & (DATA_WIDTH - 1)) != 0) begin : g_bad_data
    $error("wb_line_master: DATA_WIDTH must be a power of two >= 8");
  end
  if (LINE_WIDTH % DATA_WIDTH != 0 || (BEATS & (BEATS - 1)) != 0) begin : g_bad_line
    $error("wb_line_master: LINE_WIDTH must be a power-of-two multiple of DATA_WIDTH");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("wb_line_master: TIMEOUT_CYCLES must be positive");
  end

  line_state_e           state, state_next;
  logic [IDX_W-1:0]      beat, beat_next;
  logic                  we_q, we_next;
  logic [ADDR_WIDTH-1:0] base_q, base_next;
  logic [LINE_WIDTH-1:0] wdata_q, wdata_next;
  logic [LINE_WIDTH-1:0] rdata_q, rdata_next;
  logic [MASK_W-1:0]     wmask_q, wmask_next;
  logic                  ready_q, ready_next;
  logic                  bus_q, bus_next;
  logic                  bus_we_q, bus_we_next;
  logic [ADDR_WIDTH-1:0] adr_q, adr_next;
  logic [DATA_WIDTH-1:0] dat_q, dat_next;
  logic [SEL_W-1:0]      sel_q, sel_next;
  logic                  ack_ok;
  logic [BEATS-1:0]      live;
  logic [IDX_W:0]        hit;

`ifdef WB_LINE_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_q, tmo_next;
  logic             err_q, err_next;
`endif

  function automatic logic [BEATS-1:0] slice_live(input logic [MASK_W-1:0] m);
    logic [BEATS-1:0] v;
    v = '0;
    for (int i = 0; i < BEATS; i++) v[i] = |m[i*SEL_W +: SEL_W];
    return v;
  endfunction

  // Returns {found, index} of the lowest live beat at or above start.
  function automatic logic [IDX_W:0] find_next(input logic [BEATS-1:0] v, input int start);
    logic [IDX_W:0] r;
    r = '0;
    for (int i = BEATS - 1; i >= 0; i--)
      if (i >= start && v[i]) r = {1'b1, IDX_W'(i)};
    return r;
  endfunction

  assign ack_ok = bus_q & wb.ack_i;

  // Next-state logic; bus outputs are computed for the following cycle and registered below.
  always_comb begin
    state_next = state;
    beat_next  = beat;
    we_next    = we_q;
    base_next  = base_q;
    wdata_next = wdata_q;
    wmask_next = wmask_q;
    rdata_next = rdata_q;
    live       = '0;
    hit        = '0;
`ifdef WB_LINE_MASTER_TIMEOUT_EN
    tmo_next   = '0;
    err_next   = err_q;
`endif
    case (state)
      IDLE: begin
        if (req.req_valid_i && ready_q) begin
          we_next    = req.req_we_i;
          base_next  = req.req_addr_i & ~ADDR_WIDTH'(BEATS - 1);
          wdata_next = req.req_wdata_i;
          wmask_next = req.req_wmask_i;
          rdata_next = '0;
`ifdef WB_LINE_MASTER_TIMEOUT_EN
          err_next   = 1'b0;
`endif
          live       = req.req_we_i ? slice_live(req.req_wmask_i) : '1;
          hit        = find_next(live, 0);
          beat_next  = hit[IDX_W-1:0];
          state_next = hit[IDX_W] ? BUS : RESP;
        end
      end
      BUS: begin
        if (ack_ok) begin
          if (!we_q)
            for (int i = 0; i < BEATS; i++)
              if (IDX_W'(i) == beat) rdata_next[i*DATA_WIDTH +: DATA_WIDTH] = wb.dat_i;
          live = we_q ? slice_live(wmask_q) : '1;
          hit  = find_next(live, int'(beat) + 1);
          if (hit[IDX_W]) beat_next = hit[IDX_W-1:0];
          else            state_next = RESP;
        end
`ifdef WB_LINE_MASTER_TIMEOUT_EN
        else if (tmo_q == TMO_W'(TIMEOUT_CYCLES)) begin
          state_next = RESP;
          err_next   = 1'b1;
          rdata_next = '0;
        end else begin
          tmo_next = tmo_q + 1'b1;
        end
`endif
      end
      RESP: begin
        if (req.resp_ready_i) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    ready_next  = (state_next == IDLE);
    bus_next    = (state_next == BUS);
    bus_we_next = bus_next & we_next;
    adr_next    = bus_next ? (base_next | ADDR_WIDTH'(beat_next)) : '0;
    dat_next    = '0;
    sel_next    = '0;
    if (bus_next) begin
      for (int i = 0; i < BEATS; i++) begin
        if (IDX_W'(i) == beat_next) begin
          dat_next = we_next ? wdata_next[i*DATA_WIDTH +: DATA_WIDTH] : '0;
          sel_next = we_next ? wmask_next[i*SEL_W +: SEL_W] : '1;
        end
      end
    end
  end

  // State and registered bus outputs; reset drops cyc/stb without waiting for a clock.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state    <= IDLE;
      beat     <= '0;
      we_q     <= 1'b0;
      base_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      bus_q    <= 1'b0;
      bus_we_q <= 1'b0;
      adr_q    <= '0;
      dat_q    <= '0;
      sel_q    <= '0;
`ifdef WB_LINE_MASTER_TIMEOUT_EN
      tmo_q    <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      state    <= state_next;
      beat     <= beat_next;
      we_q     <= we_next;
      base_q   <= base_next;
      wdata_q  <= wdata_next;
      wmask_q  <= wmask_next;
      rdata_q  <= rdata_next;
      ready_q  <= ready_next;
      bus_q    <= bus_next;
      bus_we_q <= bus_we_next;
      adr_q    <= adr_next;
      dat_q    <= dat_next;
      sel_q    <= sel_next;
`ifdef WB_LINE_MASTER_TIMEOUT_EN
      tmo_q    <= tmo_next;
      err_q    <= err_next;
`endif
    end
  end

  assign req.req_ready_o  = ready_q;
  assign req.resp_valid_o = (state == RESP);
  assign req.resp_rdata_o = rdata_q;
`ifdef WB_LINE_MASTER_TIMEOUT_EN
  assign req.resp_err_o   = err_q;
`else
  assign req.resp_err_o   = 1'b0;
`endif

  assign wb.adr_o = adr_q;
  assign wb.dat_o = dat_q;
  assign wb.sel_o = sel_q;
  assign wb.we_o  = bus_we_q;
  assign wb.cyc_o = bus_q;
  assign wb.stb_o = bus_q;

endmodule

// File: tb/tb_wb_line_master.sv
// Randomized self-checking bench for wb_line_master against a RAM slave and a line-level memory model.
module tb_wb_line_master;

  localparam int AW      = 25;
  localparam int DW      = 64;
  localparam int LW      = 512;
  localparam int BEATS   = LW / DW;
  localparam int SW      = DW / 8;
  localparam int MW      = LW / 8;
  localparam int TIMEOUT = 256;
  localparam int RAMW    = 1024;

  typedef struct {
    logic [AW-1:0] adr;
    logic [SW-1:0] sel;
    logic          we;
  } beat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  bit   ramMute = 1'b0;
  bit   ramInitDone = 1'b0;
  int   checkCount = 0;
  int   errorCount = 0;
  int   cycCount = 0;
  beat_t beatLog[$];
  logic [DW-1:0] ram [RAMW];
  logic [DW-1:0] refMem [RAMW];

  wb_line_req_if #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) req_if ();
  wb_bus_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) wb_if ();

  wb_line_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TIMEOUT)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .req(req_if),
    .wb(wb_if)
  );

  always #5 clk = ~clk;

  // RAM slave: ack registered one cycle after stb and self-clearing.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_if.ack_i <= 1'b0;
      wb_if.dat_i <= '0;
      if (!ramInitDone) begin
        for (int i = 0; i < RAMW; i++) ram[i] <= 64'h1111_0000 + 64'(i);
        ramInitDone <= 1'b1;
      end
    end else begin
      wb_if.ack_i <= 1'b0;
      if (wb_if.cyc_o && wb_if.stb_o && !wb_if.ack_i && !ramMute) begin
        wb_if.ack_i <= 1'b1;
        if (wb_if.we_o) begin
          for (int j = 0; j < SW; j++)
            if (wb_if.sel_o[j]) ram[wb_if.adr_o[9:0]][j*8 +: 8] <= wb_if.dat_o[j*8 +: 8];
        end else begin
          wb_if.dat_i <= ram[wb_if.adr_o[9:0]];
        end
      end
    end
  end

  always @(posedge clk) begin
    if (wb_if.cyc_o) cycCount <= cycCount + 1;
    if (wb_if.cyc_o && wb_if.stb_o && wb_if.ack_i)
      beatLog.push_back('{adr: wb_if.adr_o, sel: wb_if.sel_o, we: wb_if.we_o});
  end

  task automatic checkOutput(input string tag, input logic [LW-1:0] observed, input logic [LW-1:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  function automatic logic [LW-1:0] refRead(input logic [AW-1:0] base);
    logic [LW-1:0] line;
    for (int b = 0; b < BEATS; b++) line[b*DW +: DW] = refMem[(int'(base[9:0]) + b) % RAMW];
    return line;
  endfunction

  task automatic refWrite(input logic [AW-1:0] base, input logic [LW-1:0] wdata, input logic [MW-1:0] wmask);
    int idx;
    for (int b = 0; b < BEATS; b++) begin
      idx = (int'(base[9:0]) + b) % RAMW;
      for (int j = 0; j < SW; j++)
        if (wmask[b*SW + j]) refMem[idx][j*8 +: 8] = wdata[b*DW + j*8 +: 8];
    end
  endtask

  function automatic logic [LW-1:0] randLine();
    logic [LW-1:0] v;
    for (int i = 0; i < LW / 32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [MW-1:0] randMask();
    logic [MW-1:0] m;
    for (int b = 0; b < BEATS; b++) begin
      case ($urandom_range(0, 2))
        0:       m[b*SW +: SW] = '0;
        1:       m[b*SW +: SW] = '1;
        default: m[b*SW +: SW] = SW'($urandom);
      endcase
    end
    return m;
  endfunction

  // One line transaction checked against the memory model; hold = cycles resp_ready_i stays low.
  task automatic applyStimulus(input string name, input logic we, input logic [AW-1:0] addr,
                               input logic [LW-1:0] wdata, input logic [MW-1:0] wmask, input int hold);
    logic [AW-1:0] base;
    logic [LW-1:0] expLine, snap;
    logic [AW-1:0] expAdr[$];
    logic [SW-1:0] expSel[$];
    int waitCnt, respCycle, expCycle, logStart, cycStart, nBeats;
    bit stable;

    base = addr & ~AW'(BEATS - 1);
    waitCnt = 0;
    @(negedge clk);
    while (!req_if.req_ready_o && waitCnt < 50) begin
      @(negedge clk);
      waitCnt++;
    end
    if (waitCnt >= 50) begin
      checkOutput({name, " ready_wait"}, 0, 1);
      resetDut();
    end

    for (int b = 0; b < BEATS; b++) begin
      if (!we || wmask[b*SW +: SW] != '0) begin
        expAdr.push_back(base + AW'(b));
        expSel.push_back(we ? wmask[b*SW +: SW] : '1);
      end
    end
    nBeats   = expAdr.size();
    expCycle = (nBeats == 0) ? 1 : 2 * nBeats + 1;
    expLine  = we ? '0 : refRead(base);
    if (we) refWrite(base, wdata, wmask);

    logStart = beatLog.size();
    cycStart = cycCount;
    req_if.req_valid_i  = 1'b1;
    req_if.req_we_i     = we;
    req_if.req_addr_i   = addr;
    req_if.req_wdata_i  = wdata;
    req_if.req_wmask_i  = wmask;
    req_if.resp_ready_i = 1'b0;
    @(posedge clk);
    #1 req_if.req_valid_i = 1'b0;

    respCycle = 0;
    for (int c = 1; c <= 400; c++) begin
      @(negedge clk);
      if (req_if.resp_valid_o) begin
        respCycle = c;
        break;
      end
    end
    checkOutput({name, " resp_cycle"}, respCycle, expCycle);
    if (respCycle == 0) begin
      resetDut();
      return;
    end
    checkOutput({name, " rdata"}, req_if.resp_rdata_o, expLine);
    checkOutput({name, " err"}, req_if.resp_err_o, 0);
    checkOutput({name, " beats"}, beatLog.size() - logStart, nBeats);
    checkOutput({name, " cyc_cycles"}, cycCount - cycStart, 2 * nBeats);
    for (int i = 0; i < nBeats && logStart + i < beatLog.size(); i++) begin
      checkOutput({name, " beat_adr"}, beatLog[logStart + i].adr, expAdr[i]);
      checkOutput({name, " beat_sel"}, beatLog[logStart + i].sel, expSel[i]);
      checkOutput({name, " beat_we"}, beatLog[logStart + i].we, we);
    end

    snap = req_if.resp_rdata_o;
    stable = 1'b1;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (!req_if.resp_valid_o || req_if.resp_rdata_o !== snap || req_if.req_ready_o) stable = 1'b0;
    end
    if (hold > 0) checkOutput({name, " hold_stable"}, stable, 1);

    req_if.resp_ready_i = 1'b1;
    checkOutput({name, " ready_in_hs"}, req_if.req_ready_o, 0);
    @(posedge clk);
    #1 req_if.resp_ready_i = 1'b0;
    @(negedge clk);
    checkOutput({name, " ready_after"}, req_if.req_ready_o, 1);
    checkOutput({name, " valid_after"}, req_if.resp_valid_o, 0);
  endtask

  initial begin
    logic [MW-1:0] sparse;
    bit sawResp;
    int waitCnt;

    for (int i = 0; i < RAMW; i++) refMem[i] = 64'h1111_0000 + 64'(i);
    req_if.req_valid_i  = 1'b0;
    req_if.req_we_i     = 1'b0;
    req_if.req_addr_i   = '0;
    req_if.req_wdata_i  = '0;
    req_if.req_wmask_i  = '0;
    req_if.resp_ready_i = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst ready", req_if.req_ready_o, 0);
    checkOutput("rst cyc", wb_if.cyc_o, 0);
    checkOutput("rst stb", wb_if.stb_o, 0);
    checkOutput("rst valid", req_if.resp_valid_o, 0);
    checkOutput("rst err", req_if.resp_err_o, 0);
    checkOutput("rst adr", wb_if.adr_o, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst ready", req_if.req_ready_o, 1);

    applyStimulus("rd40", 1'b0, 25'h40, '0, '0, 0);
    applyStimulus("wr_full", 1'b1, 25'h80, randLine(), '1, 0);
    applyStimulus("rd_full", 1'b0, 25'h85, '0, '0, 0);

    sparse = '0;
    sparse[2*SW +: SW] = 8'h0F;
    sparse[5*SW +: SW] = 8'hF0;
    applyStimulus("wr_sparse", 1'b1, 25'h103, randLine(), sparse, 0);
    applyStimulus("rd_sparse", 1'b0, 25'h100, '0, '0, 0);
    applyStimulus("wr_zero", 1'b1, 25'h140, randLine(), '0, 0);
    applyStimulus("rd_hold", 1'b0, 25'h1C0, '0, '0, 10);

    for (int n = 0; n < 24; n++) begin
      logic rwe;
      rwe = 1'($urandom);
      applyStimulus(rwe ? "rand_wr" : "rand_rd", rwe, AW'($urandom_range(0, RAMW - 1)),
                    randLine(), randMask(), $urandom_range(0, 3));
    end

    // Abort a read while beat 3 is on the bus.
    @(negedge clk);
    req_if.req_valid_i = 1'b1;
    req_if.req_we_i    = 1'b0;
    req_if.req_addr_i  = 25'h200;
    @(posedge clk);
    #1 req_if.req_valid_i = 1'b0;
    waitCnt = 0;
    begin
      int logStart;
      logStart = beatLog.size() > 3 ? beatLog.size() - 3 : 0;
      logStart = beatLog.size();
      while (beatLog.size() - logStart < 3 && waitCnt < 40) begin
        @(negedge clk);
        waitCnt++;
      end
    end
    checkOutput("abort cyc_before", wb_if.cyc_o, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort cyc", wb_if.cyc_o, 0);
    checkOutput("abort stb", wb_if.stb_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    sawResp = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_if.resp_valid_o) sawResp = 1'b1;
    end
    checkOutput("abort no_resp", sawResp, 0);
    checkOutput("abort ready", req_if.req_ready_o, 1);
    applyStimulus("rd_after_abort", 1'b0, 25'h200, '0, '0, 0);

`ifdef WB_LINE_MASTER_TIMEOUT_EN
    ramMute = 1'b1;
    @(negedge clk);
    req_if.req_valid_i = 1'b1;
    req_if.req_we_i    = 1'b0;
    req_if.req_addr_i  = 25'h240;
    @(posedge clk);
    #1 req_if.req_valid_i = 1'b0;
    sawResp = 1'b0;
    for (int c = 0; c < 2 * TIMEOUT + 20; c++) begin
      @(negedge clk);
      if (req_if.resp_valid_o) begin
        sawResp = 1'b1;
        break;
      end
    end
    checkOutput("tmo resp", sawResp, 1);
    checkOutput("tmo err", req_if.resp_err_o, 1);
    checkOutput("tmo rdata", req_if.resp_rdata_o, 0);
    checkOutput("tmo cyc", wb_if.cyc_o, 0);
    req_if.resp_ready_i = 1'b1;
    @(posedge clk);
    #1 req_if.resp_ready_i = 1'b0;
    ramMute = 1'b0;
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
